sram_req_arbiter: RTL and testbench

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Arbitrates two SRAM-like requesters (inst, data) onto one downstream bus and routes responses in order.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking; default build gives data fixed priority.
module sram_req_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int PW = (OUTSTANDING > 2) ? 2 : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);

  logic [OUTSTANDING-1:0] id_fifo;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   locked;
  logic                   lock_id;
  logic                   tie_id;
  logic                   sel;
  logic                   sel_req;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   head_id;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic last_id;

  // last_id = 0 means inst was served last, so data wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_id <= 1'b0;
    end else if (push) begin
      last_id <= sel;
    end
  end

  assign tie_id = ~last_id;
`else
  assign tie_id = 1'b1;
`endif

  // A stalled request keeps the grant so the bus fields never change mid-request
  always_comb begin
    sel = 1'b0;
    if (locked) begin
      sel = lock_id;
    end else if (inst_req && data_req) begin
      sel = tie_id;
    end else begin
      sel = data_req;
    end
  end

  assign sel_req   = sel ? data_req : inst_req;
  assign full      = (count == FULL_CNT);
  assign bus_req   = sel_req & ~full & ~reset;
  assign bus_wr    = sel ? data_wr    : inst_wr;
  assign bus_size  = sel ? data_size  : inst_size;
  assign bus_addr  = sel ? data_addr  : inst_addr;
  assign bus_wdata = sel ? data_wdata : inst_wdata;

  assign push         = bus_req & bus_addr_ok;
  assign inst_addr_ok = push & ~sel;
  assign data_addr_ok = push & sel;

  // Responses with nothing outstanding (e.g. left over from before a reset) are dropped
  assign pop          = bus_data_ok & (count != '0);
  assign head_id      = id_fifo[rd_ptr];
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign busy         = (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_fifo <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      locked  <= 1'b0;
      lock_id <= 1'b0;
    end else begin
      locked  <= bus_req & ~bus_addr_ok;
      lock_id <= sel;
      if (push) begin
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Table-driven bench for sram_req_arbiter with an in-order response scoreboard.
module tb_sram_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  sram_req_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        ir;
    bit        dr;
    bit        aok;
    bit        dok;
    bit [31:0] rdata;
    bit        e_breq;
    bit        e_sel;
    bit        e_busy;
  } vec_t;

  vec_t vecs[$];
  bit   sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit ir, input bit dr, input bit aok, input bit dok,
                     input bit [31:0] rdata, input bit e_breq, input bit e_sel, input bit e_busy);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_breq = e_breq; v.e_sel = e_sel; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  initial begin
    bit g1;
    bit head;
    bit e_iaok, e_daok, e_idok, e_ddok;
    vec_t v;

`ifdef ARB_ROUND_ROBIN_EN
    g1 = 1'b0;
`else
    g1 = 1'b1;
`endif
    //   ir dr aok dok rdata          breq sel busy
    add(1, 0, 1, 0, 32'h0,          1, 0, 0);  // single inst fetch
    add(0, 0, 0, 0, 32'h0,          0, 0, 1);
    add(0, 0, 0, 1, 32'h3C1D_0000,  0, 0, 1);
    add(0, 0, 0, 0, 32'h0,          0, 0, 0);
    add(1, 1, 1, 1, 32'hDEAD_0004,  1, 1, 0);  // continuous tie, stray data_ok first
    add(1, 1, 1, 1, 32'hDEAD_0005,  1, g1, 1);
    add(1, 1, 1, 1, 32'hDEAD_0006,  1, 1, 1);
    add(0, 0, 0, 1, 32'hDEAD_0007,  0, 0, 1);
    add(0, 1, 0, 0, 32'h0,          1, 1, 0);  // data stalled, inst joins
    add(1, 1, 0, 0, 32'h0,          1, 1, 0);
    add(1, 1, 0, 0, 32'h0,          1, 1, 0);
    add(1, 1, 1, 0, 32'h0,          1, 1, 0);
    add(0, 0, 0, 1, 32'h1234_5678,  0, 0, 1);
    add(1, 0, 1, 0, 32'h0,          1, 0, 0);  // fill to depth 2
    add(0, 1, 1, 0, 32'h0,          1, 1, 1);
    add(1, 1, 1, 0, 32'h0,          0, 0, 1);
    add(1, 0, 1, 1, 32'hAAAA_0010,  0, 0, 1);
    add(1, 0, 1, 1, 32'hAAAA_0011,  1, 0, 1);  // push and pop together
    add(0, 1, 1, 0, 32'h0,          1, 1, 1);
    add(1, 0, 1, 0, 32'h0,          0, 0, 1);
    add(0, 0, 0, 1, 32'hBBBB_0014,  0, 0, 1);
    add(0, 0, 0, 1, 32'hBBBB_0015,  0, 0, 1);
    add(0, 0, 0, 1, 32'hBBBB_0016,  0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 0, 0);

    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    inst_wr = 1'b0; data_wr = 1'b1; inst_size = 2'd2; data_size = 2'd1;
    inst_addr = 32'hBFC0_0000; data_addr = 32'h8000_1000;
    inst_wdata = 32'h0; data_wdata = 32'h0; bus_rdata = 32'h0;
    #2;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      inst_req    = v.ir;
      data_req    = v.dr;
      bus_addr_ok = v.aok;
      bus_data_ok = v.dok;
      bus_rdata   = v.rdata;
      inst_addr   = 32'hBFC0_0000 + 32'(4 * i);
      data_addr   = 32'h8000_1000 + 32'(4 * i);
      inst_wdata  = 32'hA5A5_0000 | 32'(i);
      data_wdata  = 32'h5A5A_0000 | 32'(i);
      #2;
      e_iaok = v.e_breq & v.aok & ~v.e_sel;
      e_daok = v.e_breq & v.aok & v.e_sel;
      e_idok = 1'b0;
      e_ddok = 1'b0;
      if (v.dok && sb.size() != 0) begin
        head = sb.pop_front();
        e_idok = ~head;
        e_ddok = head;
      end
      if (e_iaok) sb.push_back(1'b0);
      if (e_daok) sb.push_back(1'b1);
      chk($sformatf("v%0d_bus_req", i), 32'(bus_req), 32'(v.e_breq));
      chk($sformatf("v%0d_addr_ok", i), {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, e_iaok, e_daok});
      chk($sformatf("v%0d_data_ok", i), {30'd0, inst_data_ok, data_data_ok}, {30'd0, e_idok, e_ddok});
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.e_busy));
      chk($sformatf("v%0d_rdata", i), inst_rdata ^ data_rdata ^ bus_rdata, v.rdata);
      if (v.e_breq) begin
        chk($sformatf("v%0d_bus_addr", i), bus_addr, v.e_sel ? data_addr : inst_addr);
        chk($sformatf("v%0d_bus_wdata", i), bus_wdata, v.e_sel ? data_wdata : inst_wdata);
        chk($sformatf("v%0d_bus_ctl", i), {29'd0, bus_wr, bus_size},
            v.e_sel ? {29'd0, data_wr, data_size} : {29'd0, inst_wr, inst_size});
      end
      @(posedge clk); #1;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-cycle with one transaction outstanding
    inst_req = 1'b1; data_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
    #2;
    chk("pre_rst_hs", 32'(inst_addr_ok), 32'd1);
    @(posedge clk); #1;
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    inst_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_ok", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    #2;
    chk("post_rst_stray", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    #2;
    chk("post_rst_busy2", 32'(busy), 32'd0);
    inst_req = 1'b1; bus_addr_ok = 1'b1; inst_addr = 32'hBFC0_0100;
    #1;
    chk("post_rst_hs", 32'(inst_addr_ok), 32'd1);
    chk("post_rst_addr", bus_addr, 32'hBFC0_0100);
    @(posedge clk); #1;
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    #2;
    chk("post_rst_busy3", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
